// File: rtl/data_sram_resp.sv
// data_sram_resp: data-side synchronous SRAM responder for the five-stage pipeline.
// Read-first, byte-enabled word storage with a registered read port. An optional
// wait-state FSM adds WAIT_CYCLES of latency and raises stallreq while the
// request is outstanding.
module data_sram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          wen_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;

    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   bus_idx;
    logic                accept;
    logic                commit;
    logic [ADDR_W-1:0]   c_idx;
    logic [3:0]          c_wen;
    logic [31:0]         c_wdata;

    // Byte offset and high address bits are intentionally dropped (word
    // addressing, aliasing modulo the array size).
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign bus_idx = data_sram_addr[ADDR_W+1:2];

    // Decode this cycle's commit and pick its source: live bus in IDLE,
    // latched request in WAIT (the stalled pipeline's repeat is ignored).
    always_comb begin
        accept   = (state_q == S_IDLE) && data_sram_en;
        commit   = (accept && !HAS_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
        stallreq = (accept && HAS_WAIT) || ((state_q == S_WAIT) && (cnt_q != 4'd0));
        if (state_q == S_WAIT) begin
            c_idx   = idx_q;
            c_wen   = wen_q;
            c_wdata = wdata_q;
        end else begin
            c_idx   = bus_idx;
            c_wen   = data_sram_wen;
            c_wdata = data_sram_wdata;
        end
    end

    // Wait-state FSM, request latch and read-first output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (commit) begin
                rdata_q <= mem[c_idx];
            end
            case (state_q)
                S_IDLE: begin
                    if (data_sram_en && HAS_WAIT) begin
                        idx_q   <= bus_idx;
                        wen_q   <= data_sram_wen;
                        wdata_q <= data_sram_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset; a reset in the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (c_wen[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed scoreboard bench for data_sram_resp: one instance with no wait
// states, one with WAIT_CYCLES=3. Expected read words are pushed when a
// request is driven and popped in the cycle the registered result appears.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, stall0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;

    logic        rst3, en3, stall3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
        .data_sram_addr(addr0), .data_sram_wdata(wdata0),
        .data_sram_rdata(rdata0), .stallreq(stall0)
    );

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3),
        .data_sram_rdata(rdata3), .stallreq(stall3)
    );

    typedef struct packed {
        bit          known;
        logic [31:0] val;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];

    // Reference memory per DUT with per-byte "written" flags.
    logic [31:0] mm [2][1024];
    bit   [3:0]  kb [2][1024];

    logic [31:0] rd0, rd3;
    bit          rd0_known, rd3_known;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int d, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata);
        logic [9:0] idx;
        exp_t       e;
        idx     = addr[11:2];
        e.known = (kb[d][idx] == 4'hF);
        e.val   = mm[d][idx];
        if (d == 0) q0.push_back(e);
        else        q3.push_back(e);
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                mm[d][idx][8*i +: 8] = wdata[8*i +: 8];
                kb[d][idx][i]        = 1'b1;
            end
        end
    endtask

    task automatic step0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        exp_t e;
        en0 = en; wen0 = wen; addr0 = addr; wdata0 = wdata;
        @(negedge clk);
        chk({tag, " stall0"}, {31'b0, stall0}, 32'd0);
        if (q0.size() > 0) begin
            e = q0.pop_front();
            rd0_known = e.known;
            rd0 = e.val;
        end
        if (rd0_known) chk({tag, " rdata0"}, rdata0, rd0);
        if (en) model_push(0, wen, addr, wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic req3(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
            @(negedge clk);
            chk($sformatf("%s stall3 c%0d", tag, k), {31'b0, stall3}, (k < 3) ? 32'd1 : 32'd0);
            if (k == 0 && q3.size() > 0) begin
                e = q3.pop_front();
                rd3_known = e.known;
                rd3 = e.val;
            end
            if (rd3_known) chk($sformatf("%s rdata3 c%0d", tag, k), rdata3, rd3);
            if (k == 0) model_push(1, wen, addr, wdata);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle3(input string tag);
        exp_t e;
        en3 = 1'b0; wen3 = 4'h0;
        @(negedge clk);
        chk({tag, " stall3"}, {31'b0, stall3}, 32'd0);
        if (q3.size() > 0) begin
            e = q3.pop_front();
            rd3_known = e.known;
            rd3 = e.val;
        end
        if (rd3_known) chk({tag, " rdata3"}, rdata3, rd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; en0 = 1'b0; wen0 = '0; addr0 = '0; wdata0 = '0;
        rst3 = 1'b1; en3 = 1'b0; wen3 = '0; addr3 = '0; wdata3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst3 = 1'b0;
        rd0 = '0; rd0_known = 1'b1;
        rd3 = '0; rd3_known = 1'b1;

        // No wait states: store, read, byte write, read-first, hold, alias.
        step0(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344, "w0_store");
        step0(1'b1, 4'h0, 32'h0000_0100, 32'h0,         "w0_read");
        step0(1'b1, 4'h2, 32'h0000_0101, 32'h0000_AB00, "w0_bytewr");
        step0(1'b1, 4'h0, 32'h0000_0100, 32'h0,         "w0_read2");
        step0(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "w0_store2");
        step0(1'b0, 4'h0, 32'h0,         32'h0,         "w0_hold1");
        step0(1'b0, 4'h0, 32'h0,         32'h0,         "w0_hold2");
        step0(1'b0, 4'h0, 32'h0,         32'h0,         "w0_hold3");
        step0(1'b1, 4'h0, 32'h0000_0100, 32'h0,         "w0_read3");
        step0(1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, "w0_alias_st");
        step0(1'b1, 4'h0, 32'h0000_0000, 32'h0,         "w0_alias_rd");
        step0(1'b0, 4'h0, 32'h0,         32'h0,         "w0_flush");

        // Three wait states: store, two back-to-back reads, single-access check.
        req3(4'hF, 32'h0000_0100, 32'hDEAD_BEEF, "w3_store");
        req3(4'h0, 32'h0000_0100, 32'h0,         "w3_read");
        req3(4'h0, 32'h0000_0100, 32'h0,         "w3_read_b2b");
        idle3("w3_after");
        idle3("w3_idle");

        // Reset in the middle of a wait abandons the pending store.
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h0000_0100; wdata3 = 32'h55AA_55AA;
        @(negedge clk);
        chk("w3_rstst stall3", {31'b0, stall3}, 32'd1);
        chk("w3_rstst rdata3", rdata3, rd3);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0; en3 = 1'b0; wen3 = 4'h0;
        @(negedge clk);
        chk("w3_postrst stall3", {31'b0, stall3}, 32'd0);
        chk("w3_postrst rdata3", rdata3, 32'd0);
        rd3 = '0; rd3_known = 1'b1;
        @(posedge clk);
        #1;
        req3(4'h0, 32'h0000_0100, 32'h0, "w3_read_after_rst");
        idle3("w3_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
